// File: rtl/digit_pkg.sv
// Shared constants and FSM state type for the digit classifier datapath.
// The upstream difference stages and the bench import this package as well.
package digit_pkg;
  localparam int GRID       = 11;
  localparam int NUM_DIGITS = 10;
  localparam int SCORE_W    = 15;
  localparam int DIGIT_W    = 4;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/pixel_sum_accumulator.sv
// Clear/enable adder that sums one template's pixel differences.
// 15 bits hold 121 x 255 = 30855, so no saturation logic is needed.
module pixel_sum_accumulator
  import digit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [PIX_W-1:0]   pixel,
  output logic [SCORE_W-1:0] sum
);

  // Clear wins over enable so a new template always starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clr)
      sum <= '0;
    else if (en)
      sum <= sum + {{(SCORE_W-PIX_W){1'b0}}, pixel};
  end

endmodule

// File: rtl/digit_score_argmin.sv
// Scores every digit template by summing its pixel differences, one pixel
// per cycle, and reports the template with the smallest sum.
module digit_score_argmin #(
  parameter int NUM_DIGITS = 10,
  parameter int GRID       = 11,
  parameter int THRESHOLD  = 15000
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [NUM_DIGITS-1:0][GRID-1:0][GRID-1:0][7:0] diff_pixel,
  output logic                                           busy,
  output logic                                           done,
  output logic [digit_pkg::DIGIT_W-1:0]                  digit,
  output logic [digit_pkg::SCORE_W-1:0]                  score,
  output logic                                           match
);
  import digit_pkg::*;

  localparam int RC_W = (GRID > 1) ? $clog2(GRID) : 1;
  localparam logic [RC_W-1:0]    LAST_RC = RC_W'(GRID - 1);
  localparam logic [DIGIT_W-1:0] LAST_D  = DIGIT_W'(NUM_DIGITS - 1);
  // THRESHOLD is expected to fit the score width.
  localparam logic [SCORE_W-1:0] THR     = SCORE_W'(THRESHOLD);

  state_e               state;
  logic [RC_W-1:0]      row, col;
  logic [DIGIT_W-1:0]   dcnt;
  logic [DIGIT_W-1:0]   best_idx;
  logic [SCORE_W-1:0]   best;
  logic [SCORE_W-1:0]   acc;
  logic [PIX_W-1:0]     pixel;
  logic                 acc_clr, acc_en;
  logic                 take_new;
  logic [SCORE_W-1:0]   final_best;
  logic [DIGIT_W-1:0]   final_idx;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Current template pixel, selected by the digit/row/column counters.
  assign pixel   = diff_pixel[dcnt][row][col];
  assign acc_en  = (state == ST_ACCUM);
  assign acc_clr = ((state == ST_IDLE) && start) ||
                   ((state == ST_COMPARE) && (dcnt != LAST_D));

  pixel_sum_accumulator u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .pixel (pixel),
    .sum   (acc)
  );

  // Running argmin: strict less-than keeps the lowest index on ties.
  always_comb begin
    take_new   = (dcnt == '0) || (acc < best);
    final_best = take_new ? acc  : best;
    final_idx  = take_new ? dcnt : best_idx;
  end

  // Control FSM, pixel/digit counters, running best and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      dcnt     <= '0;
      best     <= '0;
      best_idx <= '0;
      digit    <= '0;
      score    <= '0;
      match    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            row   <= '0;
            col   <= '0;
            dcnt  <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (col == LAST_RC) begin
            col <= '0;
            if (row == LAST_RC) begin
              row   <= '0;
              state <= ST_COMPARE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_COMPARE: begin
          best     <= final_best;
          best_idx <= final_idx;
          if (dcnt != LAST_D) begin
            dcnt  <= dcnt + 1'b1;
            row   <= '0;
            col   <= '0;
            state <= ST_ACCUM;
          end else begin
            digit <= final_idx;
            score <= final_best;
            match <= (final_best <= THR);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_score_argmin.sv
// Randomised and directed bench for digit_score_argmin with a behavioural
// argmin model and per-cycle checks of busy/done/result timing.
module tb_digit_score_argmin;
  import digit_pkg::*;

  localparam int ND  = 10;
  localparam int G   = 11;
  localparam int LAT = 1220;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          start;
  logic [ND-1:0][G-1:0][G-1:0][7:0] dp;
  logic                          busy, done, match;
  logic [DIGIT_W-1:0]            digit;
  logic [SCORE_W-1:0]            score;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_d = 0, prev_s = 0, prev_m = 0;

  digit_score_argmin #(.NUM_DIGITS(ND), .GRID(G), .THRESHOLD(15000)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .diff_pixel (dp),
    .busy       (busy),
    .done       (done),
    .digit      (digit),
    .score      (score),
    .match      (match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sum each template, pick the smallest sum, lowest index on ties.
  function automatic void model(output int d, output int s, output int m);
    int sums [ND];
    d = 0;
    for (int k = 0; k < ND; k++) begin
      sums[k] = 0;
      for (int r = 0; r < G; r++)
        for (int c = 0; c < G; c++)
          sums[k] += int'(dp[k][r][c]);
    end
    s = sums[0];
    for (int k = 1; k < ND; k++)
      if (sums[k] < s) begin s = sums[k]; d = k; end
    m = (s <= 15000) ? 1 : 0;
  endfunction

  task automatic fill_all(input int v);
    for (int k = 0; k < ND; k++)
      for (int r = 0; r < G; r++)
        for (int c = 0; c < G; c++)
          dp[k][r][c] = 8'(v);
  endtask

  task automatic fill_rand(input int maxv);
    for (int k = 0; k < ND; k++)
      for (int r = 0; r < G; r++)
        for (int c = 0; c < G; c++)
          dp[k][r][c] = 8'($urandom_range(maxv, 0));
  endtask

  // One run; optional literal pins on the model, start re-pulses and reset.
  task automatic run(input string tag, input int ld, input int ls, input int lm,
                     input bit repulse, input int rst_at);
    int ed, es, em;
    model(ed, es, em);
    if (ld >= 0) chk({tag, "/model_digit"}, ed, ld);
    if (ls >= 0) chk({tag, "/model_score"}, es, ls);
    if (lm >= 0) chk({tag, "/model_match"}, em, lm);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/busy0"}, int'(busy), 1);
    chk({tag, "/done0"}, int'(done), 0);
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      start = repulse && (n == 10 || n == 600);
      reset = (n == rst_at);
      @(posedge clk); #1;
      if (n == rst_at) begin
        chk({tag, "/rst_busy"},  int'(busy),  0);
        chk({tag, "/rst_done"},  int'(done),  0);
        chk({tag, "/rst_digit"}, int'(digit), 0);
        chk({tag, "/rst_score"}, int'(score), 0);
        chk({tag, "/rst_match"}, int'(match), 0);
        prev_d = 0; prev_s = 0; prev_m = 0;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          chk({tag, "/rst_nodone"}, int'(done), 0);
          chk({tag, "/rst_idle"},   int'(busy), 0);
        end
        return;
      end
      chk({tag, "/done"}, int'(done), (n == LAT) ? 1 : 0);
      chk({tag, "/busy"}, int'(busy), (n <= LAT) ? 1 : 0);
      if (n == LAT) begin
        prev_d = ed; prev_s = es; prev_m = em;
      end
      chk({tag, "/digit"}, int'(digit), prev_d);
      chk({tag, "/score"}, int'(score), prev_s);
      chk({tag, "/match"}, int'(match), prev_m);
    end
  endtask

  initial begin
    int ed, es, em;
    reset = 1'b1;
    start = 1'b0;
    fill_all(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy",  int'(busy),  0);
    chk("reset/done",  int'(done),  0);
    chk("reset/digit", int'(digit), 0);
    chk("reset/score", int'(score), 0);
    chk("reset/match", int'(match), 0);

    // Reset beats start on the same edge.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio/busy", int'(busy), 0);
    @(negedge clk); start = 1'b0; reset = 1'b0;

    fill_all(0);
    run("zeros", 0, 0, 1, 1'b0, -1);

    fill_all(2);
    for (int r = 0; r < G; r++)
      for (int c = 0; c < G; c++) dp[7][r][c] = 8'd1;
    run("t7", 7, 121, 1, 1'b0, -1);

    fill_all(255);
    run("all255", 0, 30855, 0, 1'b0, -1);

    fill_all(0);
    for (int k = 0; k < ND; k++) begin
      if (k == 3 || k == 5) begin
        dp[k][0][0] = 8'd250; dp[k][0][1] = 8'd250;
      end else begin
        dp[k][0][0] = 8'd255; dp[k][0][1] = 8'd255; dp[k][4][7] = 8'd90;
      end
    end
    run("t3t5", 3, 500, 1, 1'b0, -1);

    fill_rand(255);
    run("repulse", -1, -1, -1, 1'b1, -1);

    fill_rand(200);
    run("midreset", -1, -1, -1, 1'b0, 500);
    run("after_rst", -1, -1, -1, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      fill_rand((i == 0) ? 255 : (i == 1) ? 200 : (i == 2) ? 150 : 124);
      run("rand", -1, -1, -1, 1'b0, -1);
    end

    // Start held high: second run begins on the first IDLE edge after DONE.
    fill_rand(180);
    model(ed, es, em);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 2 * LAT + 3; n++) begin
      @(negedge clk);
      if (n == 2 * LAT + 3) start = 1'b0;
      @(posedge clk); #1;
      chk("held/done", int'(done), (n == LAT || n == 2 * LAT + 2) ? 1 : 0);
      chk("held/busy", int'(busy), (n == LAT + 1 || n == 2 * LAT + 3) ? 0 : 1);
      if (n == LAT || n == 2 * LAT + 2) begin
        chk("held/digit", int'(digit), ed);
        chk("held/score", int'(score), es);
        chk("held/match", int'(match), em);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
